// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data memory arbiter: memory WrRd command codes,
// the arbiter FSM state encoding and the default bus widths.
// No ports (package).
// -----------------------------------------------------------------------------
package dm_pkg;

  localparam int DM_ADDR_LENGTH = 11;
  localparam int DM_DATA_LENGTH = 16;

  // Memory WrRd command codes
  localparam logic [1:0] DM_WRITE = 2'b10;
  localparam logic [1:0] DM_READ  = 2'b01;
  localparam logic [1:0] DM_IDLE  = 2'b00;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } dm_state_t;

  // Memory command for a request direction (we = 1 means write).
  function automatic logic [1:0] dm_cmd(input logic we);
    return we ? DM_WRITE : DM_READ;
  endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter_if
// Bundles the two requester ports and the single-port memory interface of the
// data memory arbiter.
//   p0_* / p1_* : requester ports (req/we/addr/wdata in, ack/err/rdata out)
//   mem_*       : memory command (wrrd/addr/wdata out) and read data (rdata in)
// Modports: slave = arbiter side, master = requester + memory model side.
//
// Handshake: pX_req is a level that is raised together with stable we/addr/
// wdata and held until pX_ack. pX_ack is a one-cycle pulse; pX_err and pX_rdata
// are valid while it is high. The arbiter samples req again on the edge that
// ends the ack cycle, so a requester that wants exactly one transaction must
// drop req (or present the next transaction) during the ack cycle; req still
// high at that edge starts a new transaction.
// -----------------------------------------------------------------------------
interface data_memory_arbiter_if
  import dm_pkg::*;
#(
  parameter int ADDR_LENGTH = DM_ADDR_LENGTH,
  parameter int DATA_LENGTH = DM_DATA_LENGTH
);

  logic                   p0_req;
  logic                   p0_we;
  logic [ADDR_LENGTH-1:0] p0_addr;
  logic [DATA_LENGTH-1:0] p0_wdata;
  logic                   p0_ack;
  logic                   p0_err;
  logic [DATA_LENGTH-1:0] p0_rdata;

  logic                   p1_req;
  logic                   p1_we;
  logic [ADDR_LENGTH-1:0] p1_addr;
  logic [DATA_LENGTH-1:0] p1_wdata;
  logic                   p1_ack;
  logic                   p1_err;
  logic [DATA_LENGTH-1:0] p1_rdata;

  logic [1:0]             mem_wrrd;
  logic [ADDR_LENGTH-1:0] mem_addr;
  logic [DATA_LENGTH-1:0] mem_wdata;
  logic [DATA_LENGTH-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_ack, p0_err, p0_rdata,
    output p1_ack, p1_err, p1_rdata,
    output mem_wrrd, mem_addr, mem_wdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_ack, p0_err, p0_rdata,
    input  p1_ack, p1_err, p1_rdata,
    input  mem_wrrd, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way round-robin winner select.
//   req0, req1   : request levels
//   last_grant   : port served most recently (0 or 1)
//   grant_valid  : at least one request present
//   grant        : winning port index (meaningful only with grant_valid)
// -----------------------------------------------------------------------------
module rr_arbiter2
  import dm_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant
);

  always_comb begin
    grant_valid = req0 | req1;
    grant       = 1'b0;
    if (req0 && req1) begin
      // Contention: the port not served last wins.
      grant = ~last_grant;
    end else if (req1) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter
// Round-robin arbiter and sequencer placing two requesters onto one
// single-port data memory. One memory command per granted request, issued for
// exactly one cycle so the memory performs it on the following negedge; read
// data is captured on the next posedge together with a one-cycle ack.
//   clk        : system clock, all state on posedge
//   rst_n      : asynchronous active-low reset
//   bus        : requester ports and memory interface (slave modport)
//   dbg_state  : current FSM state
// Parameters: ADDR_LENGTH, DATA_LENGTH, MEM_WORDS (addresses >= MEM_WORDS are
// rejected with err and never reach the memory).
// -----------------------------------------------------------------------------
module data_memory_arbiter
  import dm_pkg::*;
#(
  parameter int ADDR_LENGTH = DM_ADDR_LENGTH,
  parameter int DATA_LENGTH = DM_DATA_LENGTH,
  parameter int MEM_WORDS   = 2048
) (
  input  logic                        clk,
  input  logic                        rst_n,
  data_memory_arbiter_if.slave        bus,
  output dm_state_t                   dbg_state
);

  dm_state_t              state_q, state_d;
  logic                   last_grant_q, last_grant_d;
  logic                   grant_q, grant_d;     // port being served
  logic                   is_rd_q, is_rd_d;     // served transaction is a read
  logic                   oor_q, oor_d;         // served address out of range
  logic [1:0]             mem_wrrd_q, mem_wrrd_d;
  logic [ADDR_LENGTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_LENGTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                   p0_ack_q, p0_ack_d;
  logic                   p1_ack_q, p1_ack_d;
  logic                   p0_err_q, p0_err_d;
  logic                   p1_err_q, p1_err_d;
  logic [DATA_LENGTH-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_LENGTH-1:0] p1_rdata_q, p1_rdata_d;

  logic                   win_valid;
  logic                   win_port;
  logic                   sel_we;
  logic [ADDR_LENGTH-1:0] sel_addr;
  logic [DATA_LENGTH-1:0] sel_wdata;
  logic                   sel_oor;

  rr_arbiter2 u_arb (
    .req0        (bus.p0_req),
    .req1        (bus.p1_req),
    .last_grant  (last_grant_q),
    .grant_valid (win_valid),
    .grant       (win_port)
  );

  // Fields of the winning request.
  always_comb begin
    if (win_port) begin
      sel_we    = bus.p1_we;
      sel_addr  = bus.p1_addr;
      sel_wdata = bus.p1_wdata;
    end else begin
      sel_we    = bus.p0_we;
      sel_addr  = bus.p0_addr;
      sel_wdata = bus.p0_wdata;
    end
    sel_oor = (32'(sel_addr) >= 32'(MEM_WORDS));
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    is_rd_d      = is_rd_q;
    oor_d        = oor_q;
    mem_wrrd_d   = DM_IDLE;     // a command is only ever driven for one cycle
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    p0_ack_d     = 1'b0;
    p1_ack_d     = 1'b0;
    p0_err_d     = 1'b0;
    p1_err_d     = 1'b0;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          grant_d     = win_port;
          is_rd_d     = ~sel_we;
          oor_d       = sel_oor;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          // A rejected address still costs the ACCESS cycle but never
          // presents a command to the memory.
          mem_wrrd_d  = sel_oor ? DM_IDLE : dm_cmd(sel_we);
          state_d     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // The memory completed the access on the preceding negedge, so
        // mem_rdata is already valid here.
        last_grant_d = grant_q;
        if (grant_q) begin
          p1_ack_d = 1'b1;
          p1_err_d = oor_q;
          if (is_rd_q && !oor_q) p1_rdata_d = bus.mem_rdata;
        end else begin
          p0_ack_d = 1'b1;
          p0_err_d = oor_q;
          if (is_rd_q && !oor_q) p0_rdata_d = bus.mem_rdata;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;     // port 0 wins the first contention
      grant_q      <= 1'b0;
      is_rd_q      <= 1'b0;
      oor_q        <= 1'b0;
      mem_wrrd_q   <= DM_IDLE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p0_err_q     <= 1'b0;
      p1_err_q     <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      is_rd_q      <= is_rd_d;
      oor_q        <= oor_d;
      mem_wrrd_q   <= mem_wrrd_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      p0_err_q     <= p0_err_d;
      p1_err_q     <= p1_err_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

  assign bus.mem_wrrd  = mem_wrrd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.p0_ack    = p0_ack_q;
  assign bus.p1_ack    = p1_ack_q;
  assign bus.p0_err    = p0_err_q;
  assign bus.p1_err    = p1_err_q;
  assign bus.p0_rdata  = p0_rdata_q;
  assign bus.p1_rdata  = p1_rdata_q;
  assign dbg_state     = state_q;

endmodule
